// File: rtl/cdc_handshake_receiver.sv
// Receiving end of a two-phase req/ack CDC handshake. The foreign req toggle
// is synchronized into clk_i, the held data word is captured into a small
// first-word-fall-through FIFO, and ack is toggled back only once the word is
// actually stored, so a stalled consumer throttles the sender.
module cdc_handshake_receiver #(
    parameter int Bits       = 8,
    parameter int Depth      = 4,
    parameter int SyncStages = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_i,
    input  logic [Bits-1:0]          data_i,
    output logic                     ack_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [Bits-1:0]          data_o,
    output logic [$clog2(Depth):0]   level_o
);

    localparam int PtrW = $clog2(Depth);
    localparam logic [PtrW-1:0] PtrOne = 1;
    localparam logic [PtrW:0]   CntOne = 1;
    localparam logic [PtrW:0]   CntFull = Depth[PtrW:0];

    logic [SyncStages-1:0] req_pipe;
    logic                  req_s;
    logic                  ack_q;
    logic [PtrW-1:0]       wr_ptr, rd_ptr;
    logic [PtrW:0]         count;
    logic [Bits-1:0]       mem [Depth];

    logic pending, full, empty, push, pop;

    assign req_s = req_pipe[SyncStages-1];

    // Push/pop qualification; a push never relies on a same-cycle pop.
    always_comb begin
        pending = (req_s != ack_q);
        full    = (count == CntFull);
        empty   = (count == '0);
        push    = pending && !full;
        pop     = !empty && ready_i;
    end

    // Plain flop chain for the asynchronous req toggle, nothing in between.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) req_pipe <= '0;
        else         req_pipe <= {req_pipe[SyncStages-2:0], req_i};
    end

    // Ack follows the synchronized req only when the word has been stored.
    always_ff @(posedge clk_i) begin
        if (!rst_ni)   ack_q <= 1'b0;
        else if (push) ack_q <= req_s;
    end

    // Storage array; data_i is held stable by the sender while pending.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= data_i;
    end

    // Pointers wrap naturally at Depth; count tracks occupancy.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PtrOne;
            if (pop)  rd_ptr <= rd_ptr + PtrOne;
            case ({push, pop})
                2'b10:   count <= count + CntOne;
                2'b01:   count <= count - CntOne;
                default: count <= count;
            endcase
        end
    end

    assign ack_o   = ack_q;
    assign valid_o = !empty;
    assign data_o  = mem[rd_ptr];
    assign level_o = count;

endmodule

// File: tb/tb_cdc_handshake_receiver.sv
// Bench for cdc_handshake_receiver: a toggle sender pushes expected words into
// a queue, a negedge monitor pops and compares every accepted output word.
module tb_cdc_handshake_receiver;

    localparam int Bits = 8;
    localparam int Depth = 4;
    localparam int SyncStages = 2;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            req_i = 1'b0;
    logic [Bits-1:0] data_i = '0;
    logic            ack_o;
    logic            valid_o;
    logic            ready_i = 1'b0;
    logic [Bits-1:0] data_o;
    logic [2:0]      level_o;

    int vectors = 0;
    int miscompares = 0;
    bit rnd_ready = 1'b0;
    logic [Bits-1:0] sb_q [$];

    cdc_handshake_receiver #(.Bits(Bits), .Depth(Depth), .SyncStages(SyncStages)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .data_i(data_i),
        .ack_o(ack_o), .valid_o(valid_o), .ready_i(ready_i),
        .data_o(data_o), .level_o(level_o)
    );

    always #5 clk_i = ~clk_i;

    // Scoreboard: every word accepted downstream must match the oldest sent word.
    always @(negedge clk_i) begin
        if (rst_ni && valid_o && ready_i) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_extra: got %02h want nothing", data_o);
            end else begin
                logic [Bits-1:0] exp_w;
                exp_w = sb_q.pop_front();
                if (data_o !== exp_w) begin
                    miscompares++;
                    $display("FAIL sb_data: got %02h want %02h", data_o, exp_w);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        if (rnd_ready) ready_i = 1'($urandom_range(0, 1));
    endtask

    // Toggle-handshake one word and wait (bounded) for the ack; returns edges taken.
    task automatic send(input logic [Bits-1:0] w, output int edges);
        data_i = w;
        req_i  = ~req_i;
        sb_q.push_back(w);
        edges = 0;
        while (ack_o !== req_i && edges < 60) begin
            tick();
            edges++;
        end
        vectors++;
        if (ack_o !== req_i) begin
            miscompares++;
            $display("FAIL send_timeout: ack %0b want %0b", ack_o, req_i);
        end
    endtask

    task automatic drain();
        int n = 0;
        ready_i = 1'b1;
        while (valid_o && n < 40) begin
            tick();
            n++;
        end
        ready_i = 1'b0;
        vectors++;
        if (valid_o !== 1'b0 || level_o !== 3'd0) begin
            miscompares++;
            $display("FAIL drain_empty: valid %0b level %0d want 0 0", valid_o, level_o);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        req_i = 1'b0;
        ready_i = 1'b0;
        repeat (3) tick();
        vectors++;
        if (ack_o !== 1'b0 || valid_o !== 1'b0 || level_o !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_state: ack %0b valid %0b level %0d want 0 0 0", ack_o, valid_o, level_o);
        end
        rst_ni = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_single();
        data_i = 8'hA5;
        req_i = 1'b1;
        sb_q.push_back(8'hA5);
        tick();
        tick();
        vectors++;
        if (ack_o !== 1'b0 || valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL single_early: ack %0b valid %0b want 0 0", ack_o, valid_o);
        end
        tick();
        vectors++;
        if (ack_o !== 1'b1 || valid_o !== 1'b1 || data_o !== 8'hA5 || level_o !== 3'd1) begin
            miscompares++;
            $display("FAIL single_push: ack %0b valid %0b data %02h level %0d want 1 1 a5 1",
                     ack_o, valid_o, data_o, level_o);
        end
        repeat (4) tick();
        vectors++;
        if (ack_o !== 1'b1 || level_o !== 3'd1 || data_o !== 8'hA5) begin
            miscompares++;
            $display("FAIL single_hold: ack %0b level %0d data %02h want 1 1 a5", ack_o, level_o, data_o);
        end
        drain();
    endtask

    task automatic test_burst_full();
        int e;
        for (int i = 1; i <= 4; i++) begin
            send(8'(i), e);
            vectors++;
            if (e != SyncStages + 1) begin
                miscompares++;
                $display("FAIL burst_latency: got %0d edges want %0d", e, SyncStages + 1);
            end
        end
        vectors++;
        if (level_o !== 3'd4) begin
            miscompares++;
            $display("FAIL burst_level: got %0d want 4", level_o);
        end
        data_i = 8'h05;
        req_i = ~req_i;
        sb_q.push_back(8'h05);
        repeat (5) tick();
        vectors++;
        if (ack_o === req_i || level_o !== 3'd4) begin
            miscompares++;
            $display("FAIL full_stall: ack %0b level %0d want %0b 4", ack_o, level_o, ~req_i);
        end
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        vectors++;
        if (ack_o === req_i || level_o !== 3'd3) begin
            miscompares++;
            $display("FAIL full_pop: ack %0b level %0d want %0b 3", ack_o, level_o, ~req_i);
        end
        tick();
        vectors++;
        if (ack_o !== req_i || level_o !== 3'd4) begin
            miscompares++;
            $display("FAIL full_unblock: ack %0b level %0d want %0b 4", ack_o, level_o, req_i);
        end
        drain();
    endtask

    task automatic test_drain();
        int e;
        for (int i = 1; i <= 4; i++) send(8'(i), e);
        ready_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            vectors++;
            if (valid_o !== 1'b1 || data_o !== 8'(i)) begin
                miscompares++;
                $display("FAIL drain_seq: valid %0b data %02h want 1 %02h", valid_o, data_o, 8'(i));
            end
            tick();
        end
        ready_i = 1'b0;
        vectors++;
        if (valid_o !== 1'b0 || level_o !== 3'd0) begin
            miscompares++;
            $display("FAIL drain_end: valid %0b level %0d want 0 0", valid_o, level_o);
        end
    endtask

    task automatic test_simul();
        int e;
        send(8'h21, e);
        send(8'h22, e);
        data_i = 8'h23;
        req_i = ~req_i;
        sb_q.push_back(8'h23);
        tick();
        tick();
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        vectors++;
        if (level_o !== 3'd2 || ack_o !== req_i) begin
            miscompares++;
            $display("FAIL simul_level: level %0d ack %0b want 2 %0b", level_o, ack_o, req_i);
        end
        drain();
    endtask

    task automatic test_wrap();
        int e;
        rnd_ready = 1'b1;
        for (int i = 0; i < 10; i++) send(8'h40 + 8'(i), e);
        rnd_ready = 1'b0;
        drain();
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL wrap_lost: %0d words missing want 0", sb_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int e;
        ready_i = 1'b0;
        send(8'h77, e);
        if (req_i == 1'b1) send(8'h78, e);
        data_i = 8'h3C;
        req_i = 1'b1;
        rst_ni = 1'b0;
        tick();
        tick();
        sb_q.delete();
        vectors++;
        if (ack_o !== 1'b0 || level_o !== 3'd0 || valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_state: ack %0b level %0d valid %0b want 0 0 0", ack_o, level_o, valid_o);
        end
        rst_ni = 1'b1;
        tick();
        tick();
        vectors++;
        if (ack_o !== 1'b0 || level_o !== 3'd0) begin
            miscompares++;
            $display("FAIL midrst_early: ack %0b level %0d want 0 0", ack_o, level_o);
        end
        tick();
        vectors++;
        if (ack_o !== 1'b1 || level_o !== 3'd1 || data_o !== 8'h3C) begin
            miscompares++;
            $display("FAIL midrst_push: ack %0b level %0d data %02h want 1 1 3c", ack_o, level_o, data_o);
        end
        sb_q.push_back(8'h3C);
        repeat (4) tick();
        vectors++;
        if (level_o !== 3'd1) begin
            miscompares++;
            $display("FAIL midrst_once: level %0d want 1", level_o);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst_full();
        test_drain();
        test_simul();
        test_wrap();
        test_reset_mid();
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: %0d words want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
